// File: rtl/avg_sink_if.sv
`default_nettype none
// ============================================================================
//  Module   : avg_sink_if
//  Purpose  : Bundle of the averager result stream, the downstream drain
//             handshake and the status outputs of avg_sink.
//  Ports    : (interface, no ports)
//             ready/dout/flush  - capture stream and clear request (to sink)
//             out_valid/out_ready/out_data - FWFT drain handshake
//             count/overflow/drop_cnt/res_min/res_max - status (from sink)
//  Modports : slave  - the avg_sink block
//             master - the side driving the stream and draining results
//  Revision : 1.0 - initial release
// ============================================================================
interface avg_sink_if #(
  parameter int DW = 16,
  parameter int AW = 4
) ();

  logic          ready;
  logic [DW-1:0] dout;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic [DW-1:0] res_min;
  logic [DW-1:0] res_max;

  modport slave (
    input  ready, dout, flush, out_ready,
    output out_valid, out_data, count, overflow, drop_cnt, res_min, res_max
  );

  modport master (
    output ready, dout, flush, out_ready,
    input  out_valid, out_data, count, overflow, drop_cnt, res_min, res_max
  );

endinterface

`default_nettype wire

// File: rtl/avg_sink.sv
`default_nettype none
// ============================================================================
//  Module   : avg_sink
//  Purpose  : Collects the sliding-window averager results, keeps one out of
//             every DECIM captured results and buffers the kept ones in a
//             first-word-fall-through FIFO drained by a valid/ready handshake.
//             Reports fill level, sticky overflow and a saturating drop count.
//  Ports    : clk    - single clock, rising edge
//             reset  - synchronous, active-high
//             bus    - avg_sink_if.slave (stream in, drain out, status)
//  Options  : AVG_SINK_STATS_EN - when defined, res_min/res_max track the
//             smallest/largest kept result; otherwise they are constants.
//  Revision : 1.0 - initial release
// ============================================================================
module avg_sink #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DECIM = 1
) (
  input  wire logic   clk,
  input  wire logic   reset,
  avg_sink_if.slave   bus
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [7:0]  DC_LAST  = 8'(DECIM - 1);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [7:0]    dc_q, dc_d;

  logic keep, pop, push, drop, full;

  // --------------------------------------------------------------------------
  // Handshake decode and next state
  // --------------------------------------------------------------------------
  always_comb begin
    keep = bus.ready && (dc_q == 8'd0);
    pop  = (count_q != '0) && bus.out_ready;
    full = (count_q == FULL_LVL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push = keep && (!full || pop);
    drop = keep && !push;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    dc_d       = dc_q;

    // The decimation phase restarts at every gap in the ready stream.
    if (!bus.ready || dc_q >= DC_LAST) begin
      dc_d = 8'd0;
    end else begin
      dc_d = dc_q + 8'd1;
    end

    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
      dc_d       = 8'd0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (AW+1)'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
      dc_q       <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      dc_q       <= dc_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push && !bus.flush && !reset) begin
      mem_q[wr_ptr_q] <= bus.dout;
    end
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;

  // --------------------------------------------------------------------------
  // Optional min/max statistics over kept results (dropped ones included)
  // --------------------------------------------------------------------------
`ifdef AVG_SINK_STATS_EN
  logic [DW-1:0] res_min_q, res_min_d;
  logic [DW-1:0] res_max_q, res_max_d;

  always_comb begin
    res_min_d = res_min_q;
    res_max_d = res_max_q;
    if (bus.flush) begin
      res_min_d = '1;
      res_max_d = '0;
    end else if (keep) begin
      if (bus.dout < res_min_q) begin
        res_min_d = bus.dout;
      end
      if (bus.dout > res_max_q) begin
        res_max_d = bus.dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_min_q <= '1;
      res_max_q <= '0;
    end else begin
      res_min_q <= res_min_d;
      res_max_q <= res_max_d;
    end
  end

  assign bus.res_min = res_min_q;
  assign bus.res_max = res_max_q;
`else
  assign bus.res_min = '1;
  assign bus.res_max = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_avg_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avg_sink
//  Purpose  : Self-checking bench for avg_sink. Two instances (DECIM=1 and
//             DECIM=3) see the same stimulus; each is compared every cycle
//             against a queue-based reference model of the collector.
//  Options  : AVG_SINK_STATS_EN - selects the expected res_min/res_max rule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_avg_sink;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        t_rdy, t_flush, t_ordy;
  logic [15:0] t_dout;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  avg_sink_if #(.DW(16), .AW(4)) bus1 ();
  avg_sink_if #(.DW(16), .AW(4)) bus3 ();

  assign bus1.ready = t_rdy;   assign bus3.ready = t_rdy;
  assign bus1.dout  = t_dout;  assign bus3.dout  = t_dout;
  assign bus1.flush = t_flush; assign bus3.flush = t_flush;
  assign bus1.out_ready = t_ordy; assign bus3.out_ready = t_ordy;

  avg_sink #(.DW(16), .DEPTH(DEPTH), .AW(4), .DECIM(1)) u_d1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  avg_sink #(.DW(16), .DEPTH(DEPTH), .AW(4), .DECIM(3)) u_d3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  // ---------------------------------------------------------------- model
  logic [15:0] mq0[$];
  logic [15:0] mq1[$];
  int          run   [2];
  bit          ovf   [2];
  int          drops [2];
  logic [15:0] mn    [2];
  logic [15:0] mx    [2];

  function automatic int msize(int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [15:0] mhead(int k);
    if (k == 0) return (mq0.size() > 0) ? mq0[0] : 16'h0000;
    return (mq1.size() > 0) ? mq1[0] : 16'h0000;
  endfunction

  task automatic mclear(int k);
    if (k == 0) mq0.delete(); else mq1.delete();
    run[k] = 0; ovf[k] = 0; drops[k] = 0; mn[k] = 16'hFFFF; mx[k] = 16'h0000;
  endtask

  // One clock edge of the collector, as described behaviourally: a result
  // is kept when it is the 0th, DECIM-th, 2*DECIM-th... of an unbroken run.
  task automatic model_edge(int k, int decim);
    int sz;
    bit pop, keep;
    if (reset || t_flush) begin
      mclear(k);
    end else begin
      sz   = msize(k);
      pop  = (sz > 0) && t_ordy;
      keep = t_rdy && ((run[k] % decim) == 0);
      if (pop) begin
        if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
      end
      if (keep) begin
        if (sz < DEPTH || pop) begin
          if (k == 0) mq0.push_back(t_dout); else mq1.push_back(t_dout);
        end else begin
          ovf[k] = 1;
          if (drops[k] < 255) drops[k]++;
        end
        if (t_dout < mn[k]) mn[k] = t_dout;
        if (t_dout > mx[k]) mx[k] = t_dout;
      end
      run[k] = t_rdy ? run[k] + 1 : 0;
    end
  endtask

  // ---------------------------------------------------------------- checks
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int k, string p, logic [4:0] cnt, logic vld,
                           logic [15:0] dat, logic of, logic [7:0] dc,
                           logic [15:0] rmin, logic [15:0] rmax);
    logic [15:0] emin, emax;
`ifdef AVG_SINK_STATS_EN
    emin = mn[k];
    emax = mx[k];
`else
    emin = 16'hFFFF;
    emax = 16'h0000;
`endif
    chk({p, ".count"},     32'(cnt),  32'(msize(k)));
    chk({p, ".out_valid"}, 32'(vld),  32'(msize(k) > 0));
    chk({p, ".out_data"},  32'(dat),  32'(mhead(k)));
    chk({p, ".overflow"},  32'(of),   32'(ovf[k]));
    chk({p, ".drop_cnt"},  32'(dc),   32'(drops[k]));
    chk({p, ".res_min"},   32'(rmin), 32'(emin));
    chk({p, ".res_max"},   32'(rmax), 32'(emax));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, 1);
    model_edge(1, 3);
    #1;
    check_dut(0, "d1", bus1.count, bus1.out_valid, bus1.out_data, bus1.overflow,
              bus1.drop_cnt, bus1.res_min, bus1.res_max);
    check_dut(1, "d3", bus3.count, bus3.out_valid, bus3.out_data, bus3.overflow,
              bus3.drop_cnt, bus3.res_min, bus3.res_max);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    mclear(0);
    mclear(1);
    reset = 1'b1; t_rdy = 1'b0; t_dout = 16'h0000; t_flush = 1'b0; t_ordy = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    // Idle stream: nothing is captured.
    t_dout = 16'h1234;
    repeat (5) step();

    // Four captures, then drain in order.
    t_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t_dout = 16'h0010 + 16'(i);
      step();
    end
    t_rdy = 1'b0; t_ordy = 1'b1;
    repeat (6) step();

    // Overfill: 20 captures into 16 entries, then full drain.
    t_ordy = 1'b0; t_rdy = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      t_dout = 16'(i);
      step();
    end
    t_rdy = 1'b0; t_ordy = 1'b1;
    repeat (18) step();

    // Clear overflow, fill to full, then stream push+pop at full.
    t_flush = 1'b1; step(); t_flush = 1'b0;
    t_ordy = 1'b0; t_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      t_dout = 16'(100 + i);
      step();
    end
    t_ordy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      t_dout = 16'(200 + i);
      step();
    end
    t_rdy = 1'b0;
    repeat (18) step();

    // Decimation phase restart on a ready gap.
    t_flush = 1'b1; step(); t_flush = 1'b0;
    t_ordy = 1'b0; t_rdy = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      t_dout = 16'(i);
      step();
    end
    t_rdy = 1'b0; step();
    t_rdy = 1'b1; t_dout = 16'd10; step();
    t_rdy = 1'b0; step();

    // Statistics, then a flush that also discards a same-cycle push/pop.
    t_flush = 1'b1; step(); t_flush = 1'b0;
    t_rdy = 1'b1;
    t_dout = 16'h0300; step();
    t_dout = 16'h0100; step();
    t_dout = 16'h0500; step();
    t_rdy = 1'b0; step();
    t_flush = 1'b1; t_ordy = 1'b1; t_rdy = 1'b1; t_dout = 16'h0001; step();
    t_flush = 1'b0; t_rdy = 1'b0; step();

    // Drop counter saturation.
    t_ordy = 1'b0; t_rdy = 1'b1;
    for (int i = 0; i < 290; i++) begin
      t_dout = 16'($urandom);
      step();
    end

    // Mid-stream reset discards everything.
    reset = 1'b1; step();
    reset = 1'b0; step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      t_rdy   = ($urandom_range(0, 3) != 0);
      t_ordy  = ($urandom_range(0, 2) == 0);
      t_dout  = 16'($urandom);
      t_flush = ($urandom_range(0, 59) == 0);
      reset   = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0; t_flush = 1'b0; t_rdy = 1'b0; t_ordy = 1'b1;
    repeat (18) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/avg_sink.md
# avg_sink

Result collector for the sliding-window averager's output stream. Every cycle the averager holds `ready` high, the block captures its 16-bit `dout`, optionally decimates the stream, and buffers results in a first-word-fall-through FIFO. Downstream logic drains the FIFO through a valid/ready handshake. The block also reports fill level and overflow status.

## Interface
- `DW`, 16, result width; must match the averager `dout` width.
- `DEPTH`, 16, FIFO entries; power of two, minimum 2.
- `AW`, 4, pointer width = log2(`DEPTH`).
- `DECIM`, 1, keep one result out of every `DECIM` captured results; range 1..255.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `ready`  in  1  averager result-valid level.
- `dout`  in  DW  averager result.
- `flush`  in  1  synchronous clear of FIFO and status.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_data`  out  DW  head of FIFO; 0 when `out_valid`=0.
- `count`  out  AW+1  entries stored, 0..DEPTH.
- `overflow`  out  1  sticky: at least one result dropped because the FIFO was full.
- `drop_cnt`  out  8  dropped-result counter, saturates at 255.
- `res_min`  out  DW  smallest kept result since reset/flush.
- `res_max`  out  DW  largest kept result since reset/flush.

## Operation
- Capture: on each rising edge with `ready`=1, `dout` is a captured result.
- Decimation counter `dc` (8-bit):
  - Reset value 0; cleared whenever `ready`=0 or `flush`=1.
  - A captured result is kept when `dc`==0.
  - `dc` then advances modulo `DECIM`.
  - With `DECIM`=1 every captured result is kept.
- Push: a kept result is written at `wr_ptr` if `count`<DEPTH, or if a pop occurs in the same cycle.
- Drop: otherwise the result is dropped, `overflow` is set, and `drop_cnt` is incremented (saturating).
- Pop: when `out_valid`=1 and `out_ready`=1, `rd_ptr` advances.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop:
  - `count` is unchanged.
  - At full, this is a legal push, not an overflow.
- Empty FIFO with `out_ready`=1: no pop, pointers hold.
- Empty FIFO with a push: no bypass; the result appears on `out_data` on the next cycle.
- `flush`:
  - Pointers, `count`, `overflow`, `drop_cnt`, `dc` and statistics return to their reset values.
  - A push or pop in the same cycle is discarded.
- Priority: `reset` > `flush` > push/pop.
- Reset values: `out_valid` 0, `out_data` 0, `count` 0, `overflow` 0, `drop_cnt` 0, `res_min` 16'hFFFF, `res_max` 16'h0000.
- A reset in mid-stream discards all buffered results. Capture resumes on the first edge after `reset` deasserts.

## Timing
- Push edge to `out_valid`/`out_data` visible: 1 cycle.
- `count`, `overflow` and `drop_cnt` reflect the edge's push/pop/drop immediately after that edge.
- `out_data` is the combinational read of the head entry, gated by `out_valid`. It changes only after a pop edge, a push into an empty FIFO, or a flush/reset.
- Sustained throughput: one push and one pop per cycle.
- `dout` and `ready` are sampled at the rising edge. The averager updates them before the following edge.

## Configuration
- `AVG_SINK_STATS_EN` defined:
  - `res_min` and `res_max` update on every kept result, including dropped ones: `res_min` = min(`res_min`, value), `res_max` = max(`res_max`, value), unsigned compare.
  - The update is visible 1 cycle after capture.
- `AVG_SINK_STATS_EN` undefined:
  - No comparators or registers are built.
  - `res_min` is tied to 16'hFFFF and `res_max` to 16'h0000.
  - Ports are kept.

## Test plan
- Reset, then `ready`=0 for 5 cycles with `dout`=16'h1234 -> `count`=0, `out_valid`=0, `out_data`=0, `dc` never advances.
- `ready`=1 for 4 cycles with `dout`=16'h0010..16'h0013 and `out_ready`=0; then `out_ready`=1 -> `count` reaches 4; `out_data` is 16'h0010, 0011, 0012, 0013 on consecutive cycles; `out_valid` then drops and `count`=0.
- DEPTH=16, 20 captures (values 1..20), no pops -> `count`=16, `overflow`=1, `drop_cnt`=4; a full drain returns 1..16.
- FIFO full, `out_ready`=1, `ready`=1 for 10 cycles -> `count` stays 16, `overflow` stays 0, and output order is preserved.
- DECIM=3, `ready`=1 for 9 cycles with values 1..9 -> stored 1, 4, 7. Dropping `ready` for 1 cycle then resuming with value 10 stores 10.
- With `AVG_SINK_STATS_EN`, results 16'h0300, 16'h0100, 16'h0500 -> `res_min`=16'h0100, `res_max`=16'h0500. A `flush` pulse then gives `res_min`=16'hFFFF, `res_max`=0, `count`=0, `overflow`=0.
